// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencing controller: per-stage stall
// encodings, controller states and the multi-cycle counter width.
package pipe_ctrl_pkg;

  localparam int MC_CNT_W = 6;

  // Stall vectors, bit0 = PC up to bit5 = WB. Each hold freezes the named
  // stage and everything upstream of it.
  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_MEM  = 6'b011111;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_MC    = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  // A requested occupancy of zero cycles is treated as a single cycle.
  function automatic logic [MC_CNT_W-1:0] mc_len(input logic [MC_CNT_W-1:0] n);
    return (n == '0) ? MC_CNT_W'(1) : n;
  endfunction

endpackage

// File: rtl/pipe_mc_timer.sv
// Occupancy counter for multi-cycle EX operations. Clear wins over load,
// load wins over decrement; the count never wraps below zero.
module pipe_mc_timer
  import pipe_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                clr_n,
  input  logic                load,
  input  logic [MC_CNT_W-1:0] load_val,
  input  logic                dec,
  input  logic                clear,
  output logic [MC_CNT_W-1:0] count,
  output logic                last
);

  // Counter register: clear, load or count down toward the final cycle.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n)
      count <= '0;
    else if (clear)
      count <= '0;
    else if (load)
      count <= load_val;
    else if (dec && (count != '0))
      count <= count - MC_CNT_W'(1);
  end

  assign last = (count == MC_CNT_W'(1));

endmodule

// File: rtl/pipe_seq_ctrl.sv
// Pipeline sequencing controller: generates per-stage stalls for load-use,
// multi-cycle EX ops and memory waits, and a one-cycle flush with redirect
// target on exceptions. Optional stall cycle counter under the macro
// PIPE_STALL_PERF_CNT_EN.
module pipe_seq_ctrl
  import pipe_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        clr_n,
  input  logic        stall_id_req,
  input  logic        mc_start,
  input  logic [5:0]  mc_cycles,
  input  logic        mem_wait,
  input  logic        exc_req,
  input  logic [31:0] exc_vec,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        mc_done,
  output logic        busy
`ifdef PIPE_STALL_PERF_CNT_EN
  ,
  output logic [31:0] stall_cnt
`endif
);

  state_t              state;
  state_t              state_next;
  logic [MC_CNT_W-1:0] mc_count;
  logic                mc_last;
  logic [MC_CNT_W-1:0] mc_load_val;
  logic                mc_load;
  logic                mc_dec;
  logic                mc_clear;
  logic                ex_stall;
  logic                mc_done_next;

  assign mc_load_val = mc_len(mc_cycles);

  // The op is accepted only from RUN; an exception kills it outright.
  assign mc_load  = (state == ST_RUN) && mc_start && !exc_req;
  assign mc_dec   = (state == ST_MC) && !mem_wait && !mc_last && !exc_req;
  assign mc_clear = exc_req || ((state == ST_MC) && mc_last && !mem_wait);

  // EX holds for the issue cycle plus every MC cycle before the final one,
  // giving exactly N EX-stall cycles in total.
  assign ex_stall = ((state == ST_RUN) && mc_start) || ((state == ST_MC) && !mc_last);

  // mc_done is registered, so it is armed one cycle early: when the counter is
  // about to reach its final cycle.
  assign mc_done_next = !exc_req &&
                        (((state == ST_RUN) && mc_start && (mc_load_val == MC_CNT_W'(1))) ||
                         ((state == ST_MC) && !mem_wait && (mc_count == MC_CNT_W'(2))));

  pipe_mc_timer u_mc_timer (
    .clk      (clk),
    .clr_n    (clr_n),
    .load     (mc_load),
    .load_val (mc_load_val),
    .dec      (mc_dec),
    .clear    (mc_clear),
    .count    (mc_count),
    .last     (mc_last)
  );

  // Next-state logic; an exception overrides everything from any state.
  always_comb begin
    state_next = state;
    case (state)
      ST_RUN:   if (exc_req) state_next = ST_FLUSH;
                else if (mc_start) state_next = ST_MC;
      ST_MC:    if (exc_req) state_next = ST_FLUSH;
                else if (mc_last && !mem_wait) state_next = ST_RUN;
      ST_FLUSH: state_next = exc_req ? ST_FLUSH : ST_RUN;
      default:  state_next = ST_RUN;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n)
      state <= ST_RUN;
    else
      state <= state_next;
  end

  // Registered flush pulse, redirect target and completion pulse.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      flush   <= 1'b0;
      new_pc  <= '0;
      mc_done <= 1'b0;
    end else begin
      flush   <= exc_req;
      mc_done <= mc_done_next;
      if (exc_req)
        new_pc <= exc_vec;
    end
  end

  // Stall priority: exception (no hold) > memory wait > EX > load-use.
  always_comb begin
    stall = STALL_NONE;
    if (!clr_n)
      stall = STALL_NONE;
    else if (exc_req)
      stall = STALL_NONE;
    else if (mem_wait)
      stall = STALL_MEM;
    else if (ex_stall)
      stall = STALL_EX;
    else if (stall_id_req)
      stall = STALL_ID;
  end

  assign busy = (state != ST_RUN);

`ifdef PIPE_STALL_PERF_CNT_EN
  // Count every cycle with any stage held; wraps naturally at 2^32.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n)
      stall_cnt <= '0;
    else if (stall != STALL_NONE)
      stall_cnt <= stall_cnt + 32'd1;
  end
`endif

endmodule

// File: doc/pipe_seq_ctrl.md
PIPE_SEQ_CTRL -- requirements
Module: pipe_seq_ctrl

Interface
REQ-001 SHALL have port: clk  input  1  pipeline clock; all state updates on rising edge.
REQ-002 SHALL have port: clr_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port: stall_id_req  input  1  load-use hazard detected in ID.
REQ-004 SHALL have port: mc_start  input  1  EX issues a multi-cycle op (mult/div).
REQ-005 SHALL have port: mc_cycles  input  6  EX-occupancy N of that op, sampled with mc_start; 0 treated as 1.
REQ-006 SHALL have port: mem_wait  input  1  MEM stage awaiting memory.
REQ-007 SHALL have port: exc_req  input  1  exception or interrupt taken in MEM.
REQ-008 SHALL have port: exc_vec  input  32  handler address, sampled with exc_req.
REQ-009 SHALL have port: stall  output  6  per-stage hold; bit0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB.
REQ-010 SHALL have port: flush  output  1  one-cycle pipeline flush pulse.
REQ-011 SHALL have port: new_pc  output  32  redirect target, valid while flush=1.
REQ-012 SHALL have port: mc_done  output  1  one-cycle pulse; multi-cycle result ready.
REQ-013 SHALL have port: busy  output  1  high when state is not RUN.
REQ-014 SHALL have port (STALL_PERF_CNT_EN only): stall_cnt  output  32  count of cycles with stall!=0.

Function
REQ-015 SHALL implement states RUN, MC, FLUSH in a registered FSM.
REQ-016 stall SHALL be combinational; priority exc_req > mem_wait > EX-stall > stall_id_req.
REQ-017 Encodings SHALL be: none 000000; ID 000111; EX 001111; MEM 011111.
REQ-018 exc_req=1 in any state SHALL force stall=000000 that cycle, latch exc_vec into new_pc and enter FLUSH.
REQ-019 FLUSH SHALL last exactly one cycle with flush=1, then return to RUN; exc_req during FLUSH re-enters FLUSH with the new exc_vec.
REQ-020 An exc_req SHALL abort any MC in progress: counter cleared, no mc_done.
REQ-021 RUN with mc_start=1 and no exc_req SHALL assert EX-stall that cycle, load counter with N and enter MC.
REQ-022 In MC, the counter SHALL decrement each cycle mem_wait=0 and hold when mem_wait=1.
REQ-023 In MC with counter>1, stall SHALL be EX-stall (or MEM-stall if mem_wait).
REQ-024 In MC with counter==1 and mem_wait=0, mc_done SHALL pulse, EX-stall SHALL drop and the FSM SHALL return to RUN; total EX-stall cycles SHALL equal N.
REQ-025 mc_start while in MC or FLUSH SHALL be ignored.
REQ-026 mem_wait=1 SHALL give stall=011111 in RUN or MC; stall_id_req alone in RUN SHALL give 000111.
REQ-027 flush, mc_done and new_pc SHALL be registered outputs.

Reset
REQ-028 clr_n=0 SHALL immediately force state RUN, counter 0, flush 0, mc_done 0, new_pc 0, busy 0, stall_cnt 0.
REQ-029 stall SHALL read 000000 while clr_n=0 regardless of inputs; reset mid-MC SHALL discard the op without mc_done.

Configuration
REQ-030 Macro PIPE_STALL_PERF_CNT_EN defined SHALL add stall_cnt, incrementing by 1 each cycle stall!=0 and wrapping at 2^32-1 to 0.
REQ-031 Without PIPE_STALL_PERF_CNT_EN, stall_cnt SHALL be absent and no counter logic SHALL exist; all other behaviour is identical.

Structure
REQ-032 Package pipe_ctrl_pkg SHALL hold the four stall encodings, the state enum and the counter width.
REQ-033 Cycle counter SHALL be sub-module pipe_mc_timer (load, decrement enable, clear, last-cycle flag).

Verification
REQ-034 stall_id_req=1 one cycle in RUN -> stall=000111 that cycle only; flush=0.
REQ-035 mc_start, mc_cycles=4 -> stall=001111 for 4 cycles; mc_done pulses in 5th cycle with stall=000000.
REQ-036 mc_cycles=5, mem_wait=1 for 2 cycles mid-op -> stall=011111 during the wait; mc_done delayed 2 cycles.
REQ-037 exc_req with exc_vec=0xBFC00380 during MC -> next cycle flush=1, new_pc=0xBFC00380; no mc_done; RUN after.
REQ-038 clr_n low mid-MC -> outputs zero immediately; after release, mc_start, mc_cycles=0 -> 1 stall cycle, then mc_done.
REQ-039 With PIPE_STALL_PERF_CNT_EN, run REQ-035 -> stall_cnt=4; preload 0xFFFFFFFF -> wraps to 0.
